// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter.
// Sequences launch, busy acknowledge, completion and inter-frame gap.
module uart_tx_arbiter #(
    parameter  int NUM_REQ      = 4,
    parameter  int BUSY_TIMEOUT = 16,
    parameter  int GAP_CYCLES   = 2,
    localparam int IDW          = $clog2(NUM_REQ)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [NUM_REQ-1:0]   chan_en,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 uart_tx_busy,
    output logic                 send_en,
    output logic [7:0]           send_data,
    output logic [IDW-1:0]       grant_id,
    output logic                 arb_active,
    output logic                 timeout_err
);

    localparam int CNT_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ?
                             BUSY_TIMEOUT : GAP_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_DONE,
        GAP
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_nx;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     win;
    logic [IDW-1:0]     cand;
    logic [NUM_REQ-1:0] elig;
    logic               found;
    logic               grant;
    logic               tmo;

    assign elig       = req_valid & chan_en;
    assign arb_active = (state != IDLE);

    // Round-robin search starting just above the last winner
    always_comb begin
        win   = ptr;
        cand  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (cand == IDW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
            if (!found && elig[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Frame sequencing: next state, shared counter, one-cycle events
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        grant    = 1'b0;
        tmo      = 1'b0;
        unique case (state)
            IDLE: begin
                if (found && !uart_tx_busy) begin
                    grant    = 1'b1;
                    state_nx = WAIT_ACK;
                    cnt_nx   = '0;
                end
            end
            WAIT_ACK: begin
                if (uart_tx_busy) begin
                    state_nx = WAIT_DONE;
                end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                    tmo      = 1'b1;
                    state_nx = (GAP_CYCLES == 0) ? IDLE : GAP;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    state_nx = (GAP_CYCLES == 0) ? IDLE : GAP;
                    cnt_nx   = '0;
                end
            end
            GAP: begin
                if (cnt == CW'(GAP_CYCLES - 1)) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, pointer and registered outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            ptr         <= IDW'(NUM_REQ - 1);
            req_ready   <= '0;
            send_en     <= 1'b0;
            send_data   <= '0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            send_en     <= grant;
            timeout_err <= tmo;
            req_ready   <= '0;
            if (grant) begin
                req_ready <= NUM_REQ'(1) << win;
                send_data <= req_data[{win, 3'b000} +: 8];
                grant_id  <= win;
                ptr       <= win;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter
// against a timestamp-based reference model.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int BT  = 16;
    localparam int GAP = 2;
    localparam int INF = 'h3fff_ffff;

    logic           sys_clk = 1'b0;
    logic           sys_rst;
    logic [N-1:0]   chan_en;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           uart_tx_busy;
    logic           send_en;
    logic [7:0]     send_data;
    logic [1:0]     grant_id;
    logic           arb_active;
    logic           timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .BUSY_TIMEOUT (BT),
        .GAP_CYCLES   (GAP)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .chan_en      (chan_en),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .uart_tx_busy (uart_tx_busy),
        .send_en      (send_en),
        .send_data    (send_data),
        .grant_id     (grant_id),
        .arb_active   (arb_active),
        .timeout_err  (timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int           cyc;
        logic [7:0]   data;
        int           gid;
        logic [N-1:0] rdy;
    } launch_t;

    launch_t lq[$];
    int      tq[$];

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int         cyc = 0;
    bit         m_ok = 1'b0;
    int         m_ptr = N - 1;
    int         m_idle_from = 0;
    int         m_launch = 0;
    int         m_ack = -1;
    bit         m_pending = 1'b0;
    logic [N-1:0] e_ready = '0;
    logic       e_send = 1'b0;
    logic       e_terr = 1'b0;
    logic       e_active = 1'b0;
    logic [7:0] e_data = '0;
    int         e_gid = 0;

    // environment state
    bit [N-1:0] refill = '0;
    bit         rand_tx = 1'b0;
    bit         ext_busy = 1'b0;
    int         tx_mode = 1;
    int         ack_dly = 2;
    int         tx_len = 20;
    int         rise = 0;
    int         fall = 0;

    // Model: arbiter is free from m_idle_from onward; a launch is
    // resolved by the first busy cycle and the next idle cycle after it,
    // or by a timeout BT cycles after launch.
    always @(posedge sys_clk) begin
        logic [N-1:0] elig;
        int w;
        e_ready = '0;
        e_send  = 1'b0;
        e_terr  = 1'b0;
        if (sys_rst) begin
            m_ok        = 1'b1;
            m_ptr       = N - 1;
            e_data      = '0;
            e_gid       = 0;
            m_idle_from = cyc + 1;
            m_pending   = 1'b0;
        end else if (m_ok) begin
            if (cyc >= m_idle_from) begin
                elig = req_valid & chan_en;
                if (elig != '0 && !uart_tx_busy) begin
                    w = 0;
                    for (int k = 1; k <= N; k++) begin
                        if (elig[(m_ptr + k) % N]) begin
                            w = (m_ptr + k) % N;
                            break;
                        end
                    end
                    e_ready     = N'(1) << w;
                    e_send      = 1'b1;
                    e_data      = req_data[8*w +: 8];
                    e_gid       = w;
                    m_ptr       = w;
                    m_launch    = cyc + 1;
                    m_ack       = -1;
                    m_pending   = 1'b1;
                    m_idle_from = INF;
                end
            end else if (m_pending) begin
                if (m_ack < 0) begin
                    if (uart_tx_busy) begin
                        m_ack = cyc;
                    end else if (cyc == m_launch + BT - 1) begin
                        e_terr      = 1'b1;
                        m_idle_from = cyc + 1 + GAP;
                        m_pending   = 1'b0;
                    end
                end else if (!uart_tx_busy) begin
                    m_idle_from = cyc + 1 + GAP;
                    m_pending   = 1'b0;
                end
            end
        end
        e_active = !(cyc + 1 >= m_idle_from);
        cyc = cyc + 1;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    // One cycle: compare, log, then drive producers and transmitter
    task automatic tick();
        launch_t l;
        @(negedge sys_clk);
        if (m_ok) begin
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("send_en", 32'(send_en), 32'(e_send));
            chk("send_data", 32'(send_data), 32'(e_data));
            chk("grant_id", 32'(grant_id), 32'(e_gid));
            chk("arb_active", 32'(arb_active), 32'(e_active));
            chk("timeout_err", 32'(timeout_err), 32'(e_terr));
        end
        if (send_en) begin
            l.cyc  = cyc;
            l.data = send_data;
            l.gid  = int'(grant_id);
            l.rdy  = req_ready;
            lq.push_back(l);
            if (rand_tx) begin
                tx_mode = ($urandom_range(0, 7) == 0) ? 0 : 1;
                ack_dly = $urandom_range(0, 3);
                tx_len  = $urandom_range(1, 8);
            end
            if (tx_mode == 1) begin
                rise = cyc + ack_dly;
                fall = rise + tx_len;
            end
        end
        if (timeout_err) tq.push_back(cyc);
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] && !refill[i]) req_valid[i] = 1'b0;
        end
        uart_tx_busy = ext_busy || (cyc >= rise && cyc < fall);
    endtask

    task automatic wait_launch(string name, int n, int budget);
        int b;
        b = budget;
        while (lq.size() < n && b > 0) begin
            tick();
            b--;
        end
        chk(name, 32'(lq.size() >= n), 32'd1);
    endtask

    initial begin
        int rel;
        int l0;
        sys_rst      = 1'b1;
        chan_en      = '0;
        req_valid    = '0;
        req_data     = '0;
        uart_tx_busy = 1'b0;
        repeat (3) tick();
        chk("rst_send_data", 32'(send_data), 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'h0);
        chk("rst_arb_active", 32'(arb_active), 32'h0);
        sys_rst = 1'b0;

        // single requester
        req_data[7:0] = 8'hA5;
        chan_en   = 4'hF;
        req_valid = 4'b0001;
        lq.delete();
        wait_launch("t1_launch", 1, 20);
        repeat (40) tick();
        chk("t1_count", 32'(lq.size()), 32'd1);
        if (lq.size() > 0) begin
            chk("t1_data", 32'(lq[0].data), 32'hA5);
            chk("t1_gid", 32'(lq[0].gid), 32'd0);
            chk("t1_ready", 32'(lq[0].rdy), 32'b0001);
        end

        // all channels, fresh pointer
        sys_rst = 1'b1;
        tick();
        sys_rst   = 1'b0;
        req_data  = 32'h1312_1110;
        req_valid = 4'hF;
        refill    = 4'hF;
        lq.delete();
        wait_launch("t2_launch", 5, 300);
        for (int i = 0; i < 5 && i < lq.size(); i++) begin
            chk("t2_data", 32'(lq[i].data), 32'h10 + 32'(i % 4));
            chk("t2_gid", 32'(lq[i].gid), 32'(i % 4));
        end
        req_valid = '0;
        refill    = '0;
        repeat (40) tick();

        // disabled channel skipped until enabled
        req_data  = 32'h2300_2100;
        chan_en   = 4'b0111;
        req_valid = 4'b1010;
        lq.delete();
        wait_launch("t3_first", 1, 20);
        repeat (60) tick();
        chk("t3_count", 32'(lq.size()), 32'd1);
        if (lq.size() > 0) chk("t3_gid0", 32'(lq[0].gid), 32'd1);
        chan_en = 4'hF;
        wait_launch("t3_second", 2, 40);
        if (lq.size() > 1) begin
            chk("t3_gid1", 32'(lq[1].gid), 32'd3);
            chk("t3_data1", 32'(lq[1].data), 32'h23);
        end
        repeat (30) tick();

        // transmitter never acknowledges
        tx_mode   = 0;
        req_data  = 32'h0042_0040;
        req_valid = 4'b0101;
        lq.delete();
        tq.delete();
        wait_launch("t4_launch", 2, 80);
        chk("t4_tmo_seen", 32'(tq.size() >= 1), 32'd1);
        if (tq.size() > 0 && lq.size() > 1) begin
            chk("t4_tmo_delay", 32'(tq[0] - lq[0].cyc), 32'd16);
            chk("t4_gid0", 32'(lq[0].gid), 32'd0);
            chk("t4_gid1", 32'(lq[1].gid), 32'd2);
            chk("t4_spacing", 32'(lq[1].cyc - lq[0].cyc), 32'd19);
        end
        repeat (25) tick();
        tx_mode = 1;

        // external busy blocks the grant
        ext_busy     = 1'b1;
        uart_tx_busy = 1'b1;
        req_data     = 32'h0077_0000;
        req_valid    = 4'b0100;
        lq.delete();
        repeat (30) tick();
        chk("t5_blocked", 32'(lq.size()), 32'd0);
        ext_busy     = 1'b0;
        uart_tx_busy = 1'b0;
        rel          = cyc;
        wait_launch("t5_launch", 1, 10);
        if (lq.size() > 0) begin
            chk("t5_latency", 32'(lq[0].cyc - rel), 32'd1);
            chk("t5_gid", 32'(lq[0].gid), 32'd2);
            chk("t5_data", 32'(lq[0].data), 32'h77);
        end
        repeat (30) tick();

        // reset during WAIT_DONE
        req_data  = 32'h1312_1110;
        req_valid = 4'hF;
        refill    = 4'hF;
        lq.delete();
        wait_launch("t6_launch", 1, 20);
        repeat (5) tick();
        l0 = lq.size();
        sys_rst = 1'b1;
        tick();
        chk("t6_send_en", 32'(send_en), 32'h0);
        chk("t6_ready", 32'(req_ready), 32'h0);
        chk("t6_data", 32'(send_data), 32'h0);
        chk("t6_gid", 32'(grant_id), 32'h0);
        chk("t6_active", 32'(arb_active), 32'h0);
        chk("t6_no_launch", 32'(lq.size()), 32'(l0));
        sys_rst = 1'b0;
        lq.delete();
        wait_launch("t6_after", 1, 60);
        if (lq.size() > 0) begin
            chk("t6_after_gid", 32'(lq[0].gid), 32'd0);
            chk("t6_after_data", 32'(lq[0].data), 32'h10);
        end
        req_valid = '0;
        refill    = '0;
        repeat (40) tick();

        // randomized traffic
        rand_tx = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if ($urandom_range(0, 99) == 0)
                chan_en = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            sys_rst = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 9) == 0) begin
                    req_data[8*i +: 8] = 8'($urandom);
                    req_valid[i] = 1'b1;
                end
            end
        end
        sys_rst   = 1'b0;
        req_valid = '0;
        repeat (50) tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
